// File: rtl/watch_mode_seq.sv
// Watch mode/time-set sequencer: button edge detect, mode cycling, HH:MM digit editor, commit strobes.
// Button actions take effect at the posedge they are first seen high; optional digit blink via SET_BLINK_EN.
module watch_mode_seq #(
   parameter int BLINK_DIV = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       modeBtn,
   input  logic       setBtn,
   input  logic       nextBtn,
   input  logic       upBtn,
   input  logic [3:0] curH1,
   input  logic [3:0] curH0,
   input  logic [3:0] curM1,
   input  logic [3:0] curM0,
   output logic [2:0] mode,
   output logic       editing,
   output logic [1:0] digitSel,
   output logic [3:0] edH1,
   output logic [3:0] edH0,
   output logic [3:0] edM1,
   output logic [3:0] edM0,
   output logic       commitWatch,
   output logic       commitAlarm,
   output logic [3:0] blank
);

   typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_EDIT, ST_COMMIT} state_t;

   localparam logic [1:0] MODE_WATCH = 2'd0;
   localparam logic [1:0] MODE_ALARM = 2'd2;

   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [1:0] dsel_q, dsel_d;
   logic [3:0] h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
   logic       editing_q, editing_d;
   logic       cw_q, cw_d, ca_q, ca_d;
   logic [3:0] btn_q, btn_d, btn_edge;
   logic       mode_edge, set_edge, next_edge, up_edge;
   logic [3:0] ld_h1, ld_h0, ld_m1, ld_m0;

   assign btn_d    = {modeBtn, setBtn, nextBtn, upBtn};
   assign btn_edge = btn_d & ~btn_q;
   assign {mode_edge, set_edge, next_edge, up_edge} = btn_edge;

   // Sanitise the preload value; H0 is range-checked against the already-cleaned H1.
   always_comb begin
      ld_h1 = (curH1 > 4'd2) ? 4'd0 : curH1;
      ld_h0 = ((curH0 > 4'd9) || ((ld_h1 == 4'd2) && (curH0 > 4'd3))) ? 4'd0 : curH0;
      ld_m1 = (curM1 > 4'd5) ? 4'd0 : curM1;
      ld_m0 = (curM0 > 4'd9) ? 4'd0 : curM0;
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dsel_d  = dsel_q;
      h1_d    = h1_q;
      h0_d    = h0_q;
      m1_d    = m1_q;
      m0_d    = m0_q;
      case (state_q)
         ST_RUN: begin
            if (set_edge && ((mode_q == MODE_WATCH) || (mode_q == MODE_ALARM))) begin
               state_d = ST_LOAD;
            end else if (mode_edge) begin
               mode_d = mode_q + 2'd1;
            end
         end
         ST_LOAD: begin
            h1_d    = ld_h1;
            h0_d    = ld_h0;
            m1_d    = ld_m1;
            m0_d    = ld_m0;
            dsel_d  = 2'd3;
            state_d = ST_EDIT;
         end
         ST_EDIT: begin
            if (set_edge) begin
               state_d = ST_COMMIT;
            end else if (next_edge) begin
               dsel_d = dsel_q - 2'd1;
            end else if (up_edge) begin
               case (dsel_q)
                  2'd3: begin
                     h1_d = (h1_q >= 4'd2) ? 4'd0 : h1_q + 4'd1;
                     if ((h1_d == 4'd2) && (h0_q > 4'd3)) begin
                        h0_d = 4'd3;
                     end
                  end
                  2'd2:    h0_d = (h0_q >= ((h1_q == 4'd2) ? 4'd3 : 4'd9)) ? 4'd0 : h0_q + 4'd1;
                  2'd1:    m1_d = (m1_q >= 4'd5) ? 4'd0 : m1_q + 4'd1;
                  default: m0_d = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
               endcase
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      editing_d = (state_d != ST_RUN);
      cw_d      = (state_d == ST_COMMIT) && (mode_q == MODE_WATCH);
      ca_d      = (state_d == ST_COMMIT) && (mode_q != MODE_WATCH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RUN;
         mode_q    <= MODE_WATCH;
         dsel_q    <= 2'd3;
         h1_q      <= 4'd0;
         h0_q      <= 4'd0;
         m1_q      <= 4'd0;
         m0_q      <= 4'd0;
         editing_q <= 1'b0;
         cw_q      <= 1'b0;
         ca_q      <= 1'b0;
         btn_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         dsel_q    <= dsel_d;
         h1_q      <= h1_d;
         h0_q      <= h0_d;
         m1_q      <= m1_d;
         m0_q      <= m0_d;
         editing_q <= editing_d;
         cw_q      <= cw_d;
         ca_q      <= ca_d;
         btn_q     <= btn_d;
      end
   end

   assign mode        = {1'b0, mode_q};
   assign editing     = editing_q;
   assign digitSel    = dsel_q;
   assign edH1        = h1_q;
   assign edH0        = h0_q;
   assign edM1        = m1_q;
   assign edM0        = m0_q;
   assign commitWatch = cw_q;
   assign commitAlarm = ca_q;

`ifdef SET_BLINK_EN
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(2 * BLINK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Restart on EDIT entry and on every next/up so the touched digit shows immediately.
   always_comb begin
      cnt_d = '0;
      if ((state_d == ST_EDIT) && (state_q == ST_EDIT) && !next_edge && !up_edge) begin
         cnt_d = (cnt_q == CNT_W'(2 * BLINK_DIV - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      blank = 4'b0000;
      if ((state_q == ST_EDIT) && (cnt_q >= CNT_W'(BLINK_DIV))) begin
         blank[dsel_q] = 1'b1;
      end
   end
`else
   // BLINK_DIV has no effect without the blink feature.
   if (BLINK_DIV < 1) begin : g_blink_div_check
   end

   assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_watch_mode_seq.sv
// Self-checking bench for watch_mode_seq: vector table through a scoreboard plus reset/blink sequences.
module tb_watch_mode_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       modeBtn, setBtn, nextBtn, upBtn;
   logic [3:0] curH1, curH0, curM1, curM0;
   logic [2:0] mode;
   logic       editing;
   logic [1:0] digitSel;
   logic [3:0] edH1, edH0, edM1, edM0;
   logic       commitWatch, commitAlarm;
   logic [3:0] blank;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       name;
      logic [3:0]  btn;      // {mode, set, next, up}
      logic [15:0] cur;
      logic [2:0]  md;
      logic        eo;
      logic [1:0]  ds;
      logic [15:0] ed;
      logic        cw;
      logic        ca;
      logic        blank_only;
      logic [3:0]  blk;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   localparam logic [3:0] B_0 = 4'b0000;
   localparam logic [3:0] B_M = 4'b1000;
   localparam logic [3:0] B_S = 4'b0100;
   localparam logic [3:0] B_N = 4'b0010;
   localparam logic [3:0] B_U = 4'b0001;

   watch_mode_seq #(.BLINK_DIV(4)) dut (
      .clk(clk), .reset(reset),
      .modeBtn(modeBtn), .setBtn(setBtn), .nextBtn(nextBtn), .upBtn(upBtn),
      .curH1(curH1), .curH0(curH0), .curM1(curM1), .curM0(curM0),
      .mode(mode), .editing(editing), .digitSel(digitSel),
      .edH1(edH1), .edH0(edH0), .edM1(edM1), .edM0(edM0),
      .commitWatch(commitWatch), .commitAlarm(commitAlarm), .blank(blank)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(string nm, logic [3:0] b, logic [15:0] c, logic [2:0] md,
                               logic eo, logic [1:0] ds, logic [15:0] ed, logic cw, logic ca);
      vec_t v;
      v.name = nm; v.btn = b; v.cur = c; v.md = md; v.eo = eo; v.ds = ds;
      v.ed = ed; v.cw = cw; v.ca = ca; v.blank_only = 1'b0; v.blk = 4'b0000;
      return v;
   endfunction

   function automatic vec_t mk_blank(string nm, logic [3:0] b, logic [3:0] blk);
      vec_t v;
      v = mk(nm, b, 16'h1234, 3'd0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
      v.blank_only = 1'b1;
      v.blk = blk;
      return v;
   endfunction

   function automatic logic [31:0] exp_pack(vec_t v);
      return {3'b0, v.md, v.eo, v.ds, v.ed, v.cw, v.ca};
   endfunction

   function automatic logic [31:0] got_pack();
      return {3'b0, mode, editing, digitSel, edH1, edH0, edM1, edM0, commitWatch, commitAlarm};
   endfunction

   task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic add(string nm, logic [3:0] b, logic [15:0] c, logic [2:0] md,
                      logic eo, logic [1:0] ds, logic [15:0] ed, logic cw, logic ca);
      tbl.push_back(mk(nm, b, c, md, eo, ds, ed, cw, ca));
   endtask

   task automatic apply(vec_t v);
      vec_t e;
      @(negedge clk);
      {modeBtn, setBtn, nextBtn, upBtn} = v.btn;
      {curH1, curH0, curM1, curM0} = v.cur;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.blank_only) begin
         check(e.name, {28'b0, blank}, {28'b0, e.blk});
      end else begin
         check(e.name, got_pack(), exp_pack(e));
`ifndef SET_BLINK_EN
         check({e.name, "_blank"}, {28'b0, blank}, 32'h0);
`endif
      end
   endtask

   initial begin
      logic [2:0]  md;
      logic [15:0] c;

      // Mode cycling: 1 clk pressed, 2 released, five times
      for (int i = 0; i < 5; i++) begin
         md = 3'((i + 1) % 4);
         add("mode_press", B_M, 16'h1234, md, 0, 2'd3, 16'h0000, 0, 0);
         add("mode_rel1",  B_0, 16'h1234, md, 0, 2'd3, 16'h0000, 0, 0);
         add("mode_rel2",  B_0, 16'h1234, md, 0, 2'd3, 16'h0000, 0, 0);
      end
      add("set_in_stopwatch", B_S, 16'h1234, 3'd1, 0, 2'd3, 16'h0000, 0, 0);
      add("stopwatch_stays",  B_0, 16'h1234, 3'd1, 0, 2'd3, 16'h0000, 0, 0);
      add("mode_to_alarm",    B_M, 16'h1234, 3'd2, 0, 2'd3, 16'h0000, 0, 0);
      add("rel",              B_0, 16'h1234, 3'd2, 0, 2'd3, 16'h0000, 0, 0);
      // Alarm edit with out-of-range preload 2F:7A
      c = 16'h2F7A;
      add("alarm_set",    B_S, c, 3'd2, 1, 2'd3, 16'h0000, 0, 0);
      add("alarm_load",   B_0, c, 3'd2, 1, 2'd3, 16'h2000, 0, 0);
      add("alarm_commit", B_S, c, 3'd2, 1, 2'd3, 16'h2000, 0, 1);
      add("alarm_run",    B_0, c, 3'd2, 0, 2'd3, 16'h2000, 0, 0);
      // set+mode together: set wins, mode unchanged; H0 clamp on preload 25:59
      c = 16'h2559;
      add("set_mode_prio",  B_M | B_S, c, 3'd2, 1, 2'd3, 16'h2000, 0, 0);
      add("load_h0_clamp",  B_0, c, 3'd2, 1, 2'd3, 16'h2059, 0, 0);
      add("alarm_commit2",  B_S, c, 3'd2, 1, 2'd3, 16'h2059, 0, 1);
      add("alarm_run2",     B_0, c, 3'd2, 0, 2'd3, 16'h2059, 0, 0);
      c = 16'h3A6C;
      add("alarm_set3",     B_S, c, 3'd2, 1, 2'd3, 16'h2059, 0, 0);
      add("load_all_bad",   B_0, c, 3'd2, 1, 2'd3, 16'h0000, 0, 0);
      add("alarm_commit3",  B_S, c, 3'd2, 1, 2'd3, 16'h0000, 0, 1);
      add("alarm_run3",     B_0, c, 3'd2, 0, 2'd3, 16'h0000, 0, 0);
      add("mode_to_day",    B_M, c, 3'd3, 0, 2'd3, 16'h0000, 0, 0);
      add("rel",            B_0, c, 3'd3, 0, 2'd3, 16'h0000, 0, 0);
      add("set_in_day",     B_S, c, 3'd3, 0, 2'd3, 16'h0000, 0, 0);
      add("day_stays",      B_0, c, 3'd3, 0, 2'd3, 16'h0000, 0, 0);
      add("mode_to_watch",  B_M, c, 3'd0, 0, 2'd3, 16'h0000, 0, 0);
      add("rel",            B_0, c, 3'd0, 0, 2'd3, 16'h0000, 0, 0);
      // Watch edit 12:34, H1 up twice
      c = 16'h1234;
      add("watch_set",    B_S, c, 3'd0, 1, 2'd3, 16'h0000, 0, 0);
      add("watch_load",   B_0, c, 3'd0, 1, 2'd3, 16'h1234, 0, 0);
      add("up_h1",        B_U, c, 3'd0, 1, 2'd3, 16'h2234, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd3, 16'h2234, 0, 0);
      add("up_h1_wrap",   B_U, c, 3'd0, 1, 2'd3, 16'h0234, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd3, 16'h0234, 0, 0);
      add("watch_commit", B_S, c, 3'd0, 1, 2'd3, 16'h0234, 1, 0);
      add("watch_run",    B_0, c, 3'd0, 0, 2'd3, 16'h0234, 0, 0);
      // Edit 19:59: clamp, per-digit wraps, digit select wrap
      c = 16'h1959;
      add("set",          B_S, c, 3'd0, 1, 2'd3, 16'h0234, 0, 0);
      add("load",         B_0, c, 3'd0, 1, 2'd3, 16'h1959, 0, 0);
      add("up_h1_clamp",  B_U, c, 3'd0, 1, 2'd3, 16'h2359, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd3, 16'h2359, 0, 0);
      add("mode_ignored", B_M, c, 3'd0, 1, 2'd3, 16'h2359, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd3, 16'h2359, 0, 0);
      add("next_h0",      B_N, c, 3'd0, 1, 2'd2, 16'h2359, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd2, 16'h2359, 0, 0);
      add("up_h0_wrap3",  B_U, c, 3'd0, 1, 2'd2, 16'h2059, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd2, 16'h2059, 0, 0);
      add("next_m1",      B_N, c, 3'd0, 1, 2'd1, 16'h2059, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd1, 16'h2059, 0, 0);
      add("next_m0",      B_N, c, 3'd0, 1, 2'd0, 16'h2059, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd0, 16'h2059, 0, 0);
      add("up_m0_wrap",   B_U, c, 3'd0, 1, 2'd0, 16'h2050, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd0, 16'h2050, 0, 0);
      add("next_wrap",    B_N, c, 3'd0, 1, 2'd3, 16'h2050, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd3, 16'h2050, 0, 0);
      add("next_h0b",     B_N, c, 3'd0, 1, 2'd2, 16'h2050, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd2, 16'h2050, 0, 0);
      add("next_m1b",     B_N, c, 3'd0, 1, 2'd1, 16'h2050, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd1, 16'h2050, 0, 0);
      add("up_m1_wrap",   B_U, c, 3'd0, 1, 2'd1, 16'h2000, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd1, 16'h2000, 0, 0);
      // Held up button: exactly one increment
      for (int i = 0; i < 20; i++)
         add("hold_up",   B_U, c, 3'd0, 1, 2'd1, 16'h2010, 0, 0);
      add("rel",          B_0, c, 3'd0, 1, 2'd1, 16'h2010, 0, 0);
      add("set_next_up",  B_S | B_N | B_U, c, 3'd0, 1, 2'd1, 16'h2010, 1, 0);
      add("run_after",    B_0, c, 3'd0, 0, 2'd1, 16'h2010, 0, 0);
      // Into an alarm edit, to be interrupted by reset below
      add("mode_1",       B_M, c, 3'd1, 0, 2'd1, 16'h2010, 0, 0);
      add("rel",          B_0, c, 3'd1, 0, 2'd1, 16'h2010, 0, 0);
      add("mode_2",       B_M, c, 3'd2, 0, 2'd1, 16'h2010, 0, 0);
      add("rel",          B_0, c, 3'd2, 0, 2'd1, 16'h2010, 0, 0);
      c = 16'h1234;
      add("alarm_set4",   B_S, c, 3'd2, 1, 2'd1, 16'h2010, 0, 0);
      add("alarm_load4",  B_0, c, 3'd2, 1, 2'd3, 16'h1234, 0, 0);

      reset = 1'b1;
      {modeBtn, setBtn, nextBtn, upBtn} = 4'b0000;
      {curH1, curH0, curM1, curM0} = 16'h1234;
      @(negedge clk);
      @(negedge clk);
      check("reset_state", got_pack(), {3'b0, 3'd0, 1'b0, 2'd3, 16'h0000, 1'b0, 1'b0});
      check("reset_blank", {28'b0, blank}, 32'h0);
      reset = 1'b0;

      foreach (tbl[i]) apply(tbl[i]);

`ifdef SET_BLINK_EN
      // EDIT entered on the last table row, counter at 0, digitSel 3
      apply(mk_blank("blink_next", B_N, 4'b0000));
      apply(mk_blank("blink_rel",  B_0, 4'b0000));
      apply(mk_blank("blink_next", B_N, 4'b0000));
      for (int i = 0; i < 3; i++) apply(mk_blank("blink_shown", B_0, 4'b0000));
      for (int i = 0; i < 4; i++) apply(mk_blank("blink_blank", B_0, 4'b0010));
      for (int i = 0; i < 4; i++) apply(mk_blank("blink_shown2", B_0, 4'b0000));
      for (int i = 0; i < 2; i++) apply(mk_blank("blink_blank2", B_0, 4'b0010));
      apply(mk_blank("blink_up_restart", B_U, 4'b0000));
      for (int i = 0; i < 3; i++) apply(mk_blank("blink_after_up", B_0, 4'b0000));
      apply(mk_blank("blink_blank3", B_0, 4'b0010));
`endif

      // Asynchronous reset in the middle of an alarm edit
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midedit_reset", got_pack(), {3'b0, 3'd0, 1'b0, 2'd3, 16'h0000, 1'b0, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++)
         apply(mk("post_reset_idle", B_0, 16'h1234, 3'd0, 0, 2'd3, 16'h0000, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
